simon_data_in: RTL and testbench

- Ingress packet parser for the SIMON cipher core.
- Captures one (2+N/2)-byte packet from the link (info byte, count byte, payload).
- Decodes whether the payload is a key or a data block and presents it on KEY or blockIN.
- Handshakes the hand-off with the key-schedule / datapath consumers, then signals packet completion back to the source.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/simon_data_in.sv | 124 ++++++++++++
 tb/tb_simon_data_in.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared constants and types for the SIMON cipher core.
// Info-byte layout, ingress FSM states and default geometry.
package simon_pkg;

  localparam int N_DEF  = 16;
  localparam int M_DEF  = 4;
  localparam int T_DEF  = 32;
  localparam int CB_DEF = 5;

  localparam int INFO_VALID = 7;
  localparam int INFO_KEY   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LD,
    S_WAIT_REL,
    S_DONE
  } state_e;

endpackage

// File: rtl/simon_data_in.sv
// SIMON ingress packet parser: captures one packet, presents it
// as a key or data block and handshakes it to the consumers.
module simon_data_in
  import simon_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int M    = M_DEF,
  parameter int T    = T_DEF,
  parameter int Cb   = CB_DEF,
  parameter int MODE = 0
) (
  input  logic                    clk,
  input  logic                    nR,
  input  logic                    newPkt,
  input  logic [1+N/2:0][7:0]     in,
  input  logic                    loadData,
  input  logic                    loadKey,
  input  logic                    doneData,
  input  logic                    doneKey,
  output logic                    loadPkt,
  output logic                    donePkt,
  output logic                    newData,
  output logic                    newKey,
  output logic [7:0]              infoIN,
  output logic [7:0]              countIN,
  output logic [1:0][N-1:0]       blockIN,
  output logic [M-1:0][N-1:0]     KEY
);

  localparam int PW = 4 * N;

  if (M * N != PW || T < 1 || Cb < 1 || MODE > 1) begin : g_bad_cfg
    $error("simon_data_in: unsupported parameter set");
  end

  state_e                 state_q, state_d;
  logic [7:0]             info_q;
  logic [7:0]             count_q;
  logic [PW-1:0]          pl_q;
  logic [M-1:0][N-1:0]    key_q;
  logic [1:0][N-1:0]      blk_q;

  logic is_key, is_valid, ld, dn;

  assign is_key   = info_q[INFO_KEY];
  assign is_valid = info_q[INFO_VALID];
  assign ld       = is_key ? loadKey : loadData;
  assign dn       = is_key ? doneKey : doneData;

  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (newPkt) state_d = S_LOAD;
      S_LOAD:     state_d = is_valid ? S_WAIT_LD : S_DONE;
      S_WAIT_LD: begin
        // abort takes priority over a simultaneous load
        if (dn)      state_d = S_DONE;
        else if (ld) state_d = S_WAIT_REL;
      end
      S_WAIT_REL: if (!ld) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    loadPkt = 1'b0;
    donePkt = 1'b0;
    newKey  = 1'b0;
    newData = 1'b0;
    unique case (state_q)
      S_LOAD:    loadPkt = 1'b1;
      S_WAIT_LD: begin
        newKey  = is_key;
        newData = !is_key;
      end
      S_DONE:    donePkt = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      info_q  <= '0;
      count_q <= '0;
      pl_q    <= '0;
    end else if (state_q == S_IDLE && newPkt) begin
      info_q  <= in[1+N/2];
      count_q <= in[N/2];
      pl_q    <= in[N/2-1:0];
    end
  end

  // Key/data registers change only when a valid packet of their type lands
  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      key_q <= '0;
      blk_q <= '0;
    end else if (state_q == S_LOAD && is_valid) begin
      if (is_key) begin
        for (int i = 0; i < M; i++) begin
          key_q[M-1-i] <= pl_q[PW-1-i*N -: N];
        end
      end else begin
        blk_q[1] <= pl_q[PW-1 -: N];
        blk_q[0] <= pl_q[PW-1-N -: N];
      end
    end
  end

  assign infoIN  = info_q;
  assign countIN = count_q;
  assign blockIN = blk_q;
  assign KEY     = key_q;

endmodule

// File: tb/tb_simon_data_in.sv
// Self-checking bench for the SIMON ingress packet parser.
// Offered key/data blocks are checked against a scoreboard queue.
module tb_simon_data_in;

  logic             clk;
  logic             nR;
  logic             newPkt;
  logic [9:0][7:0]  pin;
  logic             loadData, loadKey, doneData, doneKey;
  logic             loadPkt, donePkt, newData, newKey;
  logic [7:0]       infoIN, countIN;
  logic [1:0][15:0] blockIN;
  logic [3:0][15:0] KEY;

  simon_data_in dut (
    .clk      (clk),
    .nR       (nR),
    .newPkt   (newPkt),
    .in       (pin),
    .loadData (loadData),
    .loadKey  (loadKey),
    .doneData (doneData),
    .doneKey  (doneKey),
    .loadPkt  (loadPkt),
    .donePkt  (donePkt),
    .newData  (newData),
    .newKey   (newKey),
    .infoIN   (infoIN),
    .countIN  (countIN),
    .blockIN  (blockIN),
    .KEY      (KEY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_key;
    logic [63:0] pl;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_key;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [79:0] PKT_KEY  = 80'hA0001918111009080100;
  localparam logic [79:0] PKT_DATA = 80'h80016565687721403F21;
  localparam logic [79:0] PKT_INV  = 80'h0005DEADBEEF01234567;
  localparam logic [79:0] PKT_KEY2 = 80'hA50233445566778899AA;
  localparam logic [79:0] PKT_KEY3 = 80'hA1030F0E0D0C0B0A0908;
  localparam logic [79:0] PKT_DAT2 = 80'h9F04CAFEF00D12345678;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [79:0] p, input string nm);
    logic got;
    exp_t e;
    pin    = p;
    newPkt = 1'b1;
    if (p[79]) begin
      e.is_key = p[77];
      e.pl     = p[63:0];
      sb.push_back(e);
    end
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      got = loadPkt;
    end
    newPkt = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin
      n_bad++;
      $display("FAIL %s loadPkt: got %b want 1", nm, got);
    end
    n_cmp++;
    if ({infoIN, countIN} !== p[79:64]) begin
      n_bad++;
      $display("FAIL %s info/count: got %h want %h",
               nm, {infoIN, countIN}, p[79:64]);
    end
    tick();
    n_cmp++;
    if (loadPkt !== 1'b0) begin
      n_bad++;
      $display("FAIL %s loadPkt width: got %b want 0", nm, loadPkt);
    end
  endtask

  task automatic check_offer(input string nm);
    logic got;
    exp_t e;
    got = newKey | newData;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      got = newKey | newData;
    end
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s offer: got none want one (queue %0d)",
               nm, sb.size());
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if ({newKey, newData} !== {e.is_key, !e.is_key}) begin
      n_bad++;
      $display("FAIL %s type: got k%b d%b want k%b",
               nm, newKey, newData, e.is_key);
    end
    n_cmp++;
    if (e.is_key) begin
      model_key = e.pl;
      if (KEY !== e.pl) begin
        n_bad++;
        $display("FAIL %s KEY: got %h want %h", nm, KEY, e.pl);
      end
    end else begin
      if (blockIN !== e.pl[63:32]) begin
        n_bad++;
        $display("FAIL %s blockIN: got %h want %h",
                 nm, blockIN, e.pl[63:32]);
      end
    end
    n_cmp++;
    if (KEY !== model_key) begin
      n_bad++;
      $display("FAIL %s KEY kept: got %h want %h", nm, KEY, model_key);
    end
  endtask

  task automatic wait_done(input string nm);
    int seen;
    int offers;
    seen   = 0;
    offers = 0;
    for (int i = 0; i < 8; i++) begin
      if (donePkt === 1'b1) seen++;
      if (newKey === 1'b1 || newData === 1'b1) offers++;
      tick();
    end
    n_cmp++;
    if (seen != 1) begin
      n_bad++;
      $display("FAIL %s donePkt pulses: got %0d want 1", nm, seen);
    end
    n_cmp++;
    if (offers != 0) begin
      n_bad++;
      $display("FAIL %s stray offer: got %0d want 0", nm, offers);
    end
  endtask

  task automatic test_reset();
    nR = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({loadPkt, donePkt, newData, newKey, infoIN, countIN,
         blockIN, KEY} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got nonzero want 0");
    end
    nR = 1'b0;
    model_key = '0;
    tick();
  endtask

  task automatic test_key();
    drive_pkt(PKT_KEY, "key");
    check_offer("key");
    loadKey = 1'b1;
    tick();
    n_cmp++;
    if (newKey !== 1'b0) begin
      n_bad++;
      $display("FAIL key newKey drop: got %b want 0", newKey);
    end
    tick();
    n_cmp++;
    if (donePkt !== 1'b0) begin
      n_bad++;
      $display("FAIL key hold: got donePkt %b want 0", donePkt);
    end
    loadKey = 1'b0;
    wait_done("key");
  endtask

  task automatic test_data();
    drive_pkt(PKT_DATA, "data");
    check_offer("data");
    loadData = 1'b1;
    tick();
    loadData = 1'b0;
    wait_done("data");
  endtask

  task automatic test_invalid();
    drive_pkt(PKT_INV, "inv");
    wait_done("inv");
  endtask

  task automatic test_abort();
    drive_pkt(PKT_KEY2, "abort");
    check_offer("abort");
    doneKey = 1'b1;
    tick();
    doneKey = 1'b0;
    n_cmp++;
    if ({newKey, donePkt} !== 2'b01) begin
      n_bad++;
      $display("FAIL abort: got newKey %b donePkt %b want 0 1",
               newKey, donePkt);
    end
    tick();
    drive_pkt(PKT_KEY3, "both");
    check_offer("both");
    loadKey = 1'b1;
    doneKey = 1'b1;
    tick();
    loadKey = 1'b0;
    doneKey = 1'b0;
    n_cmp++;
    if (donePkt !== 1'b1) begin
      n_bad++;
      $display("FAIL both strobes: got donePkt %b want 1", donePkt);
    end
    tick();
  endtask

  task automatic test_wrong_strobe();
    drive_pkt(PKT_KEY, "wrong");
    check_offer("wrong");
    loadData = 1'b1;
    doneData = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({newKey, donePkt} !== 2'b10) begin
      n_bad++;
      $display("FAIL wrong strobe: got newKey %b donePkt %b want 1 0",
               newKey, donePkt);
    end
    loadData = 1'b0;
    doneData = 1'b0;
    loadKey  = 1'b1;
    tick();
    loadKey  = 1'b0;
    wait_done("wrong");
  endtask

  task automatic test_reset_mid();
    drive_pkt(PKT_KEY3, "rmid");
    check_offer("rmid");
    nR = 1'b1;
    #1;
    n_cmp++;
    if ({loadPkt, donePkt, newData, newKey, infoIN, countIN,
         blockIN, KEY} !== '0) begin
      n_bad++;
      $display("FAIL reset mid: got nonzero outputs want 0");
    end
    model_key = '0;
    pin    = PKT_DAT2;
    newPkt = 1'b1;
    tick();
    nR = 1'b0;
    drive_pkt(PKT_DAT2, "recap");
    check_offer("recap");
    loadData = 1'b1;
    tick();
    loadData = 1'b0;
    wait_done("recap");
  endtask

  initial begin
    nR       = 1'b1;
    newPkt   = 1'b0;
    pin      = '0;
    loadData = 1'b0;
    loadKey  = 1'b0;
    doneData = 1'b0;
    doneKey  = 1'b0;
    model_key = '0;
    test_reset();
    test_key();
    test_data();
    test_invalid();
    test_abort();
    test_wrong_strobe();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d queued want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
